// File: rtl/timer_sched.sv
// Round-robin scheduler sharing one up-counter among NUM_REQ requesters.
// A winner gets gnt for L cycles, then a one-cycle done pulse; dropping req aborts the run.
module timer_sched #(
    parameter int  NUM_REQ   = 4,
    parameter int  MAX_COUNT = 10,
    localparam int CNT_W     = $clog2(MAX_COUNT) + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt_out
);

    // state | meaning
    // IDLE  | no run active; arbitrate among pending requests
    // RUN   | winner holds gnt, counter advances once per cycle
    // DONE  | one-cycle done pulse to the winner, count holds run length

    localparam int                 PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CNT_W-1:0]   len_arr [NUM_REQ];
    logic               arb_found;
    logic [PTR_W-1:0]   arb_win;
    logic [PTR_W:0]     arb_cand;
    logic [CNT_W-1:0]   arb_len;
    logic [PTR_W-1:0]   next_ptr;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr[g] = req_len[g*CNT_W +: CNT_W];
    end

    // Scan upward from ptr with wrap; the extra bit keeps ptr+i from overflowing before the wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (arb_cand >= (PTR_W+1)'(NUM_REQ))
                arb_cand = arb_cand - (PTR_W+1)'(NUM_REQ);
            if (!arb_found && req[arb_cand[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = arb_cand[PTR_W-1:0];
            end
        end
    end

    assign arb_len  = (len_arr[arb_win] > MAX_CNT) ? MAX_CNT : len_arr[arb_win];
    assign next_ptr = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arb_found) begin
                    win_d   = arb_win;
                    len_d   = arb_len;
                    state_d = (arb_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort wins over completion: a dropped request never sees done.
                if (!req[win_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ptr_d   = next_ptr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1)
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        if (state_q == RUN)
            gnt[win_q] = 1'b1;
        if (state_q == DONE)
            done[win_q] = 1'b1;
    end

    assign busy    = (state_q == RUN) || (state_q == DONE);
    assign cnt_out = cnt_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: each request is modelled as a whole transaction (winner, clamped
// length, abort or reset point) and the expected per-cycle outputs are derived from it.
module tb_timer_sched;

    localparam int NUM_REQ   = 4;
    localparam int MAX_COUNT = 10;
    localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

    logic                     tb_clk = 1'b0;
    logic                     reset_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [CNT_W-1:0]         cnt_out;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;

    always #5 tb_clk = ~tb_clk;

    timer_sched #(
        .NUM_REQ  (NUM_REQ),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk    (tb_clk),
        .reset_n(reset_n),
        .req    (req),
        .req_len(req_len),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt_out(cnt_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic int clamp(input int v);
        return (v > MAX_COUNT) ? MAX_COUNT : v;
    endfunction

    function automatic logic [NUM_REQ*CNT_W-1:0] mk(input int a, input int b, input int c, input int d);
        return {CNT_W'(d), CNT_W'(c), CNT_W'(b), CNT_W'(a)};
    endfunction

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  32'(gnt),     32'd0);
        chk({tag, "_done"}, 32'(done),    32'd0);
        chk({tag, "_busy"}, 32'(busy),    32'd0);
        chk({tag, "_cnt"},  32'(cnt_out), 32'd0);
    endtask

    // mode 0: normal run, 1: winner drops req in RUN cycle 'at', 2: reset asserted in RUN cycle 'at'
    task automatic txn(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*CNT_W-1:0] lv,
                       input int mode, input int at, input logic [NUM_REQ*CNT_W-1:0] lv_mid);
        int w;
        int len;
        req     = r;
        req_len = lv;
        chk_idle("idle_pre");
        w = pick(r, ptr_m);
        if (w < 0) begin
            step();
            chk_idle("idle_noreq");
            return;
        end
        len = clamp(int'(lv[w*CNT_W +: CNT_W]));
        step();
        for (int c = 0; c < len; c++) begin
            chk("run_gnt",  32'(gnt),     32'(1 << w));
            chk("run_cnt",  32'(cnt_out), 32'(c));
            chk("run_busy", 32'(busy),    32'd1);
            chk("run_done", 32'(done),    32'd0);
            if (c == 0) req_len = lv_mid;
            if (mode == 1 && c == at) begin
                req[w] = 1'b0;
                step();
                chk_idle("abort");
                ptr_m = (w + 1) % NUM_REQ;
                return;
            end
            if (mode == 2 && c == at) begin
                req     = '0;
                reset_n = 1'b0;
                #1;
                chk_idle("async_rst");
                ptr_m = 0;
                @(negedge tb_clk);
                reset_n = 1'b1;
                step();
                chk_idle("post_rst");
                return;
            end
            step();
        end
        chk("done_pulse", 32'(done),    32'(1 << w));
        chk("done_gnt",   32'(gnt),     32'd0);
        chk("done_busy",  32'(busy),    32'd1);
        chk("done_cnt",   32'(cnt_out), 32'(len));
        ptr_m = (w + 1) % NUM_REQ;
        step();
        chk_idle("idle_post");
    endtask

    initial begin
        logic [NUM_REQ*CNT_W-1:0] lv;
        logic [NUM_REQ*CNT_W-1:0] lv2;
        reset_n = 1'b1;
        req     = '0;
        req_len = '0;
        #2 reset_n = 1'b0;
        #1;
        chk_idle("reset");
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        reset_n = 1'b1;
        step();
        chk_idle("reset_rel");

        lv = mk(2, 2, 2, 2);
        repeat (5) txn(4'b1111, lv, 0, 0, lv);

        lv = mk(3, 0, 0, 0);
        txn(4'b0001, lv, 0, 0, lv);

        lv = mk(0, 0, 15, 0);
        txn(4'b0100, lv, 0, 0, lv);

        lv = mk(0, 0, 0, 0);
        txn(4'b0010, lv, 0, 0, lv);

        lv = mk(8, 2, 0, 0);
        txn(4'b0011, lv, 1, 2, lv);
        txn(4'b0010, lv, 0, 0, lv);

        lv  = mk(0, 0, 0, 4);
        lv2 = mk(0, 0, 0, 9);
        txn(4'b1000, lv, 0, 0, lv2);

        lv = mk(8, 0, 0, 0);
        txn(4'b0001, lv, 2, 5, lv);
        lv = mk(2, 2, 2, 2);
        txn(4'b1010, lv, 0, 0, lv);

        for (int n = 0; n < 40; n++) begin
            lv  = (NUM_REQ*CNT_W)'($urandom);
            lv2 = (NUM_REQ*CNT_W)'($urandom);
            txn(NUM_REQ'($urandom_range(0, 15)), lv,
                ($urandom_range(0, 5) == 0) ? 1 : 0, int'($urandom_range(0, 9)), lv2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Round-robin scheduler that shares one up-counter timer resource among NUM_REQ requesters.
- Each requester asks for a timed run of a given length.
- The block arbitrates between requests, sequences the counter through the run, and returns a one-cycle done pulse to the winner.
- Sits between requester logic and the counter datapath; cnt_out exposes the live count, with the same width rule as the counter.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_COUNT, 10: maximum run length in cycles; longer requests are clamped to this value.
- CNT_W, $clog2(MAX_COUNT)+1: derived localparam, not overridable; width of lengths and count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; must be held until done or the requester abandons the run.
- req_len  in  NUM_REQ*CNT_W  packed run lengths; slice i is bits [i*CNT_W +: CNT_W].
- gnt  out  NUM_REQ  one-hot grant; high only while the winner's run is in progress (RUN state).
- done  out  NUM_REQ  one-hot, single-cycle completion pulse.
- busy  out  1  high in RUN and DONE.
- cnt_out  out  CNT_W  current count value.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE; gnt=0, done=0, busy=0, cnt_out=0.
  - Round-robin pointer set so requester 0 has highest priority first.
- States:
  - IDLE: cnt_out=0, gnt=0, busy=0.
    - If any req bit is high, select winner w = first set bit scanning from ptr upward, mod NUM_REQ.
    - Latch w and L = min(req_len[w], MAX_COUNT).
    - Next state RUN if L>0; if L==0, next state DONE.
  - RUN: gnt[w]=1, busy=1.
    - cnt_out=0 in the first RUN cycle and increments by 1 each cycle.
    - When cnt_out==L-1, next state DONE with cnt_out=L.
    - A RUN therefore lasts exactly L cycles.
  - DONE: done[w]=1 for exactly one cycle, gnt=0, busy=1.
    - cnt_out=L (0 for a zero-length run).
    - Next state IDLE; ptr=(w+1) mod NUM_REQ.
- Latency: req sampled high in IDLE at edge t gives gnt at t+1 and done at t+1+L; the next arbitration happens in IDLE at t+2+L.
- Abort:
  - If req[w] is low in any RUN cycle, next state IDLE; no done pulse, cnt_out=0.
  - ptr still advances to (w+1) mod NUM_REQ.
- Fixed values during a run:
  - req_len is sampled only in IDLE; changes during RUN are ignored.
  - Requests from non-winners are ignored (they wait) during RUN and DONE.
- Re-request: a requester that keeps req high after done re-enters arbitration. It wins again only if no other requester is pending at or after ptr.
- Clamping: req_len > MAX_COUNT is treated as MAX_COUNT. cnt_out never exceeds MAX_COUNT, so no wrap-around is possible.
- Simultaneous requests: exactly one winner per arbitration; gnt and done are always one-hot or zero.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronously); no done pulse.

Test Plan:
- Single request: req=4'b0001, req_len[0]=3 → gnt=4'b0001 for 3 cycles with cnt_out 0,1,2; then done[0]=1 for one cycle with cnt_out=3; then IDLE with cnt_out=0.
- Fairness: req=4'b1111 held, all lengths 2 → grant order 0,1,2,3,0; each run is 2 RUN cycles + 1 DONE + 1 IDLE (4-cycle period).
- Clamp and zero length:
  - req_len[2]=15 with MAX_COUNT=10 → 10 RUN cycles, done with cnt_out=10.
  - req_len[1]=0 → done[1] pulse with gnt never high.
- Abort: req[0] length 8 dropped at RUN cycle 3 → next cycle IDLE, done stays 0, cnt_out=0. A pending req[1] is then granted next.
- Mid-run reset: reset_n low while cnt_out=5 → gnt, done, busy, cnt_out all 0 without waiting for a clock edge. After release, req=4'b1010 grants requester 1 first.
- Latch: req_len[3] changed from 4 to 9 during requester 3's run → run still lasts 4 cycles.
